// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider width, divider state encoding and the divide opcode.
package alu_pkg;

  localparam int DIV_WIDTH = 32;

  // Opcode seen by both the result-select mux and the control unit.
  localparam logic [3:0] ALU_OP_DIV = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One non-restoring division iteration on a WIDTH+1 bit signed partial remainder.
module div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] div_ext;

  assign shifted = {rem_in[WIDTH-1:0], dividend_bit};
  assign div_ext = {1'b0, divisor};

  // A negative remainder is pulled back up by adding, otherwise subtract.
  assign rem_out = rem_in[WIDTH] ? (shifted + div_ext) : (shifted - div_ext);
  assign q_bit   = ~rem_out[WIDTH];

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle signed divider: one quotient bit per clock, sign fix-up in a final cycle.
//   state | meaning
//   IDLE  | waiting for start, outputs hold the last result
//   RUN   | WIDTH non-restoring iterations on the operand magnitudes
//   FIX   | remainder correction, sign application, done pulse
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t     state, state_nx;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] bmag;
  logic             sign_a;
  logic             sign_q;
  logic             dz;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH:0]   rem_fix;
  logic [WIDTH-1:0] r_mag;

  // Magnitudes are unsigned, so -2^(WIDTH-1) maps onto itself correctly.
  assign a_mag   = a[WIDTH-1] ? -a : a;
  assign b_mag   = b[WIDTH-1] ? -b : b;
  assign rem_fix = prem[WIDTH] ? (prem + {1'b0, bmag}) : prem;
  assign r_mag   = rem_fix[WIDTH-1:0];
  assign busy    = (state != IDLE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (prem),
    .dividend_bit (qreg[WIDTH-1]),
    .divisor      (bmag),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (b == '0) ? FIX : RUN;
      RUN:  if (count == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      prem        <= '0;
      qreg        <= '0;
      bmag        <= '0;
      sign_a      <= 1'b0;
      sign_q      <= 1'b0;
      dz          <= 1'b0;
      count       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            prem        <= '0;
            qreg        <= a_mag;
            bmag        <= b_mag;
            sign_a      <= a[WIDTH-1];
            sign_q      <= a[WIDTH-1] ^ b[WIDTH-1];
            dz          <= (b == '0);
            count       <= '0;
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          prem  <= step_rem;
          qreg  <= {qreg[WIDTH-2:0], step_q};
          count <= count + CW'(1);
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dz;
          // On divide by zero qreg still holds |a|, so re-signing it gives a back.
          if (dz) begin
            quotient  <= '1;
            remainder <= sign_a ? -qreg : qreg;
          end else begin
            quotient  <= sign_q ? -qreg : qreg;
            remainder <= sign_a ? -r_mag : r_mag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// Randomized and directed bench for alu_divider against a latency-plus-arithmetic model.
module tb_alu_divider;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  quotient, remainder;

  int n_checks = 0;
  int n_pass   = 0;

  alu_divider #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic: 64-bit signed division truncates toward zero with no overflow.
  task automatic ref_div(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         output logic [W-1:0] oq, output logic [W-1:0] orr, output logic odz);
    longint sa, sb, lq, lr;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    if (sb == 0) begin
      oq = '1; orr = ia; odz = 1'b1;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      oq = lq[W-1:0]; orr = lr[W-1:0]; odz = 1'b0;
    end
  endtask

  // Model: an accepted request completes WIDTH+1 edges later (1 edge for b==0).
  logic          m_busy, m_done, m_dz, p_dz;
  logic [W-1:0]  m_q, m_r, p_q, p_r;
  int            m_left;

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_q = '0; m_r = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_q = p_q; m_r = p_r; m_dz = p_dz;
        end
      end else if (start) begin
        ref_div(a, b, p_q, p_r, p_dz);
        m_busy = 1'b1;
        m_dz   = 1'b0;
        m_left = (b == '0) ? 1 : W + 1;
      end
    end
  end

  always @(negedge clock) begin
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    check("done", {31'b0, done}, {31'b0, m_done});
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
    check("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dz});
  end

  // Issue one request and wait (bounded) for done; lat counts edges after the start edge.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, output int lat);
    @(posedge clock); #1;
    a = ia; b = ib; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!done) check("done_timeout", 32'(lat), 32'(W + 1));
  endtask

  initial begin
    int lat;
    clear = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    repeat (3) @(posedge clock);
    #1 clear = 1'b1;

    do_op(32'd100, 32'd7, lat);
    check("lat_100_7", 32'(lat), 32'd33);
    check("q_100_7", quotient, 32'd14);
    check("r_100_7", remainder, 32'd2);
    check("dz_100_7", {31'b0, div_by_zero}, 32'd0);

    do_op(-32'sd100, 32'd7, lat);
    check("q_m100_7", quotient, 32'hFFFF_FFF2);
    check("r_m100_7", remainder, 32'hFFFF_FFFE);

    do_op(32'd100, -32'sd7, lat);
    check("q_100_m7", quotient, 32'hFFFF_FFF2);
    check("r_100_m7", remainder, 32'd2);

    do_op(32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("lat_ovf", 32'(lat), 32'd33);
    check("q_ovf", quotient, 32'h8000_0000);
    check("r_ovf", remainder, 32'd0);
    check("dz_ovf", {31'b0, div_by_zero}, 32'd0);

    do_op(32'd5, 32'd0, lat);
    check("lat_dz", 32'(lat), 32'd1);
    check("q_dz", quotient, 32'hFFFF_FFFF);
    check("r_dz", remainder, 32'd5);
    check("dz_flag", {31'b0, div_by_zero}, 32'd1);

    do_op(32'd9, 32'd3, lat);
    check("q_9_3", quotient, 32'd3);
    check("r_9_3", remainder, 32'd0);
    check("dz_cleared", {31'b0, div_by_zero}, 32'd0);

    // Second start while busy must be ignored.
    @(posedge clock); #1;
    a = 32'd50; b = 32'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1 a = 32'd9; b = 32'd2; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    lat = 10;
    while (!done && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    check("lat_ignored", 32'(lat), 32'd33);
    check("q_50_5", quotient, 32'd10);
    check("r_50_5", remainder, 32'd0);
    repeat (40) @(posedge clock);
    #1 check("busy_after_ignored", {31'b0, busy}, 32'd0);

    // Abort mid-operation with clear, then rerun.
    @(posedge clock); #1;
    a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (9) @(posedge clock);
    #2 clear = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    @(posedge clock); #1 clear = 1'b1;
    repeat (3) @(posedge clock);
    do_op(32'd1000, 32'd3, lat);
    check("lat_rerun", 32'(lat), 32'd33);
    check("q_1000_3", quotient, 32'd333);
    check("r_1000_3", remainder, 32'd1);

    // Random traffic, including start held through busy and on the done cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      start = ((i / 500) % 2 == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: b = W'($urandom_range(1, 15));
        3: b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = W'($urandom_range(0, 200));
        default: a = $urandom;
      endcase
    end
    start = 1'b0;
    repeat (40) @(posedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
